// File: rtl/mem_port_arbiter.sv
// Two-port arbiter/sequencer for the unified single-port MIPS memory.
// Serialises single-word transfers through a fixed IDLE/ISSUE/WAIT/DONE sequence.
module mem_port_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic [CW-1:0] conflict_cnt
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t state, state_nxt;
    logic   owner;
    logic   last;
    logic   winner;
    logic   any_req;
    logic   both_req;

    assign any_req  = req0 | req1;
    assign both_req = req0 & req1;
    // On a tie the port that was not served last wins; otherwise the lone requester.
    assign winner   = both_req ? ~last : ~req0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner        <= 1'b0;
            last         <= 1'b1;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            rdata        <= '0;
            conflict_cnt <= '0;
        end else begin
            // Transfer attributes are captured once; later port changes are ignored.
            if (state == IDLE && any_req) begin
                owner     <= winner;
                mem_we    <= winner ? we1    : we0;
                mem_addr  <= winner ? addr1  : addr0;
                mem_wdata <= winner ? wdata1 : wdata0;
            end
            if (state == WAIT) begin
                last <= owner;
                if (!mem_we) rdata <= mem_rdata;
            end
            if (state == IDLE && both_req && conflict_cnt != {CW{1'b1}})
                conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

    assign busy   = (state != IDLE);
    assign mem_en = (state == ISSUE);
    assign gnt0   = busy & ~owner;
    assign gnt1   = busy &  owner;
    assign ack0   = (state == DONE) & ~owner;
    assign ack1   = (state == DONE) &  owner;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small synchronous-read memory model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic        gnt0, gnt1, ack0, ack1, mem_en, mem_we, busy;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [31:0] mem_rdata;
    logic [3:0]  conflict_cnt;

    logic [31:0] mem [256];
    int checks = 0;
    int errors = 0;
    int ack_clash = 0;

    mem_port_arbiter #(.AW(32), .DW(32), .CW(4)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1), .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    // Memory: write on mem_en&&mem_we, read data available the cycle after mem_en.
    always @(posedge clk) begin
        if (!reset) begin
            mem[8'h10] <= 32'hDEADBEEF;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[7:0]];
        end
    end

    always @(negedge clk) if (ack0 && ack1) ack_clash++;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        repeat (2) tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if ({gnt0, gnt1, ack0, ack1, mem_en, mem_we, busy} !== 7'b0) begin errors++;
            $display("FAIL reset_ctl got %b want 0000000", {gnt0, gnt1, ack0, ack1, mem_en, mem_we, busy}); end
        checks++; if ({rdata, mem_addr, mem_wdata, conflict_cnt} !== '0) begin errors++;
            $display("FAIL reset_data got %h %h %h %h want 0", rdata, mem_addr, mem_wdata, conflict_cnt); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle busy got %b want 0", busy); end
    endtask

    task automatic test_single_read();
        req0 = 1; we0 = 0; addr0 = 32'h10; wdata0 = 32'h0;
        tick();
        checks++; if ({mem_en, mem_we, gnt0, gnt1} !== 4'b1010) begin errors++;
            $display("FAIL rd_issue en/we/g0/g1 got %b want 1010", {mem_en, mem_we, gnt0, gnt1}); end
        checks++; if (mem_addr !== 32'h10) begin errors++; $display("FAIL rd_addr got %h want 10", mem_addr); end
        tick();
        checks++; if ({mem_en, ack0, gnt1} !== 3'b000) begin errors++;
            $display("FAIL rd_wait en/ack0/g1 got %b want 000", {mem_en, ack0, gnt1}); end
        tick();
        checks++; if ({ack0, ack1, gnt1} !== 3'b100) begin errors++;
            $display("FAIL rd_done ack0/ack1/g1 got %b want 100", {ack0, ack1, gnt1}); end
        checks++; if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got %h want deadbeef", rdata); end
        req0 = 0;
        tick();
        checks++; if ({busy, ack0} !== 2'b00) begin errors++; $display("FAIL rd_end busy/ack0 got %b want 00", {busy, ack0}); end
    endtask

    task automatic test_single_write();
        req1 = 1; we1 = 1; addr1 = 32'h20; wdata1 = 32'h12345678;
        tick();
        checks++; if ({mem_en, mem_we, gnt0, gnt1} !== 4'b1101) begin errors++;
            $display("FAIL wr_issue en/we/g0/g1 got %b want 1101", {mem_en, mem_we, gnt0, gnt1}); end
        checks++; if (mem_wdata !== 32'h12345678) begin errors++; $display("FAIL wr_wdata got %h want 12345678", mem_wdata); end
        repeat (2) tick();
        checks++; if ({ack0, ack1} !== 2'b01) begin errors++; $display("FAIL wr_ack got %b want 01", {ack0, ack1}); end
        checks++; if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rdata_kept got %h want deadbeef", rdata); end
        req1 = 0; we1 = 0;
        tick();
        req0 = 1; we0 = 0; addr0 = 32'h20;
        repeat (3) tick();
        checks++; if ({ack0, rdata} !== {1'b1, 32'h12345678}) begin errors++;
            $display("FAIL wr_readback ack0/rdata got %b %h want 1 12345678", ack0, rdata); end
        req0 = 0;
        tick();
    endtask

    task automatic test_tie();
        do_reset();
        addr0 = 32'h10; addr1 = 32'h20; we0 = 0; we1 = 0;
        req0 = 1; req1 = 1;
        tick();
        checks++; if ({gnt0, gnt1, conflict_cnt} !== {2'b10, 4'd1}) begin errors++;
            $display("FAIL tie_first g0/g1/cnt got %b%b %0d want 10 1", gnt0, gnt1, conflict_cnt); end
        repeat (2) tick();
        checks++; if ({ack0, ack1} !== 2'b10) begin errors++; $display("FAIL tie_ack0 got %b want 10", {ack0, ack1}); end
        repeat (2) tick();
        checks++; if ({gnt0, gnt1} !== 2'b01) begin errors++; $display("FAIL tie_second got %b want 01", {gnt0, gnt1}); end
        repeat (2) tick();
        checks++; if ({ack0, ack1, rdata} !== {2'b01, 32'h12345678}) begin errors++;
            $display("FAIL tie_ack1 got %b %h want 01 12345678", {ack0, ack1}, rdata); end
        for (int k = 0; k < 4; k++) begin
            repeat (2) tick();
            checks++; if ({gnt1, gnt0} !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin errors++;
                $display("FAIL tie_alt%0d g1g0 got %b want %b", k, {gnt1, gnt0}, (k % 2 == 0) ? 2'b01 : 2'b10); end
            repeat (2) tick();
        end
        req0 = 0; req1 = 0;
        tick();
        checks++; if (conflict_cnt !== 4'd6) begin errors++; $display("FAIL tie_cnt got %0d want 6", conflict_cnt); end
    endtask

    task automatic test_saturation();
        do_reset();
        addr0 = 32'h10; addr1 = 32'h20; we0 = 0; we1 = 0;
        req0 = 1; req1 = 1;
        repeat (56) tick();
        checks++; if (conflict_cnt !== 4'd14) begin errors++; $display("FAIL sat_mid got %0d want 14", conflict_cnt); end
        repeat (24) tick();
        checks++; if (conflict_cnt !== 4'd15) begin errors++; $display("FAIL sat_top got %0d want 15", conflict_cnt); end
        req0 = 0; req1 = 0;
        tick();
        checks++; if ({busy, conflict_cnt} !== {1'b0, 4'd15}) begin errors++;
            $display("FAIL sat_hold busy/cnt got %b %0d want 0 15", busy, conflict_cnt); end
    endtask

    task automatic test_reset_mid();
        req0 = 1; we0 = 1; addr0 = 32'h30; wdata0 = 32'hCAFEF00D;
        repeat (3) tick();
        req0 = 0; we0 = 0;
        tick();
        req1 = 1; we1 = 0; addr1 = 32'h20; wdata1 = 32'h55AA55AA;
        repeat (2) tick();
        #1 reset = 1'b0;
        #1;
        checks++; if ({gnt0, gnt1, ack0, ack1, mem_en, mem_we, busy} !== 7'b0) begin errors++;
            $display("FAIL rstmid_ctl got %b want 0000000", {gnt0, gnt1, ack0, ack1, mem_en, mem_we, busy}); end
        checks++; if ({rdata, mem_addr, mem_wdata, conflict_cnt} !== '0) begin errors++;
            $display("FAIL rstmid_data got %h %h %h %h want 0", rdata, mem_addr, mem_wdata, conflict_cnt); end
        tick();
        checks++; if ({ack1, busy} !== 2'b00) begin errors++; $display("FAIL rstmid_noack got %b want 00", {ack1, busy}); end
        reset = 1'b1;
        tick();
        checks++; if ({gnt1, mem_en, mem_addr} !== {2'b11, 32'h20}) begin errors++;
            $display("FAIL rstmid_reissue got %b%b %h want 11 20", gnt1, mem_en, mem_addr); end
        repeat (2) tick();
        checks++; if ({ack1, rdata} !== {1'b1, 32'h12345678}) begin errors++;
            $display("FAIL rstmid_done got %b %h want 1 12345678", ack1, rdata); end
        req1 = 0;
        tick();
    endtask

    task automatic test_early_drop();
        req0 = 1; we0 = 0; addr0 = 32'h10;
        tick();
        req0 = 0; we0 = 1; addr0 = 32'h44;
        tick();
        checks++; if ({mem_addr, mem_we} !== {32'h10, 1'b0}) begin errors++;
            $display("FAIL drop_latched got %h %b want 10 0", mem_addr, mem_we); end
        tick();
        checks++; if ({ack0, rdata} !== {1'b1, 32'hDEADBEEF}) begin errors++;
            $display("FAIL drop_ack got %b %h want 1 deadbeef", ack0, rdata); end
        tick();
        checks++; if ({busy, ack0} !== 2'b00) begin errors++; $display("FAIL drop_idle got %b want 00", {busy, ack0}); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_stay got %b want 0", busy); end
        we0 = 0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_tie();
        test_saturation();
        test_reset_mid();
        test_early_drop();
        checks++; if (ack_clash !== 0) begin errors++; $display("FAIL dual_ack got %0d want 0", ack_clash); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer for the single-port unified instruction/data memory of the multicycle MIPS core. Port 0 is the CPU memory interface (fetch, lw, sw address path); port 1 is the program loader/debug port. The block serialises single-word transfers from both onto one registered memory port, returns read data and a one-cycle acknowledge, and counts contention cycles.

## Interface
- AW, 32, address width
- DW, 32, data width
- CW, 16, width of saturating contention counter

- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- req0 / req1  in  1  transfer request; held high until ackN
- we0 / we1  in  1  1 = write, 0 = read; stable while reqN high
- addr0 / addr1  in  AW  word address; stable while reqN high
- wdata0 / wdata1  in  DW  write data; stable while reqN high
- gnt0 / gnt1  out  1  port owns memory (ISSUE..DONE)
- ack0 / ack1  out  1  one-cycle completion pulse
- rdata  out  DW  last read result, shared by both ports
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid one cycle after mem_en
- busy  out  1  state != IDLE
- conflict_cnt  out  CW  cycles where both req high in IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. Encoding free.
- IDLE: no req high -> stay. Any req high -> ISSUE. Latch winner's addr/we/wdata into mem_addr/mem_we/mem_wdata and record winner in `owner`.
- Winner selection: one req -> that port. Both -> round-robin, port != `last`. `last` resets to 1, so port 0 wins the first tie. `last` <= owner on entering DONE.
- ISSUE: mem_en=1, gnt[owner]=1. Always goes to WAIT.
- WAIT: mem_en=0, gnt[owner]=1. Read: rdata <= mem_rdata at end of cycle. Write: rdata unchanged. Always goes to DONE.
- DONE: ack[owner]=1 for exactly one cycle, gnt[owner]=1. Always goes to IDLE. The requester drops req in the cycle after ack.
- mem_addr/mem_we/mem_wdata hold their values outside ISSUE. They change only on IDLE->ISSUE.
- mem_we is qualified by mem_en: the memory writes only when mem_en=1 && mem_we=1.
- conflict_cnt: +1 in each IDLE cycle with req0 && req1. Saturates at 2^CW-1 with no wrap.
- Protocol violation: if req drops before ack, the transfer still completes and ack still pulses. Port input changes after IDLE->ISSUE are ignored.
- Both ports acked in the same cycle: impossible by construction. Bench asserts ack0 && ack1 never occurs.
- Reset is asynchronous, active-low, and takes effect mid-transfer. State -> IDLE, abandoned transfer gets no ack. All outputs reset to 0: gnt0, gnt1, ack0, ack1, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy, conflict_cnt. `last` = 1.

## Timing
- Request sampled high in IDLE at edge t gives: ISSUE in cycle t+1 (mem_en=1), WAIT in t+2, DONE in t+3 (ack=1, rdata valid for reads), IDLE in t+4.
- Fixed 4-cycle occupancy per transfer, including IDLE. The next grant is earliest at IDLE->ISSUE.
- Under continuous contention the ports alternate strictly: 0,1,0,1...
- rdata is registered. It is valid from the DONE cycle until the next read's WAIT edge.
- All outputs are registered or decoded from state/owner. No combinational path from inputs to outputs.
- Memory contract: synchronous read, data valid the cycle after mem_en.

## Test plan
- Single read, port 0: addr0=0x10, memory word 0xDEADBEEF. Expect mem_en high one cycle at t+1 with mem_addr=0x10 and mem_we=0. Expect ack0 at t+3 with rdata=0xDEADBEEF, and gnt1 low throughout.
- Single write, port 1: addr1=0x20, wdata1=0x12345678. Expect mem_we=1, mem_en=1 at t+1, ack1 at t+3, rdata unchanged. A follow-up port-0 read of 0x20 returns 0x12345678.
- Tie after reset: req0 and req1 both rise the same cycle. Expect port 0 serviced first (ack0), then port 1 (ack1 four cycles later), conflict_cnt=1. Hold both reqs continuously: grants alternate 0,1,0,1.
- Counter saturation with CW=4: force 20 contended IDLE cycles. Expect conflict_cnt stuck at 15.
- Reset during WAIT of a port-1 read: expect all outputs 0 immediately and no ack1. After reset release with req1 still high, a fresh 4-cycle transfer completes.
- Early req drop: deassert req0 during ISSUE. Expect ack0 still at t+3 and FSM back to IDLE at t+4.
